spi_imu_responder: RTL
======================

Name: spi_imu_responder

Overview:
- SPI mode-3 responder (slave) that emulates the accelerometer/gyro sensor at the far end of the sensor SPI link; it answers the master's CS/SPC/SDI with SDO.
- Contains a 128-address register map: WHO_AM_I, writable control bytes, and 12 output bytes (96-bit sample) loaded from a host-side sample port.
- Used in simulation and as an FPGA stand-in sensor, so the master path can run without real hardware.

Parameters:
- WHO_AM_I_VAL, 8'h69, constant returned at address 0x0F.
- OUT_BASE, 7'h22, address of the first output byte; output bytes occupy OUT_BASE..OUT_BASE+11.
- SYNC_STAGES, 2, synchronizer depth for CS/SPC/SDI (minimum 2).

Ports:
- clk  in  1  system clock; must be ≥8x SPC frequency; SPC high/low phases each ≥4 clk.
- reset  in  1  synchronous, active-high.
- CS  in  1  chip select, active-low, asynchronous to clk.
- SPC  in  1  SPI clock; idles high (mode 3), asynchronous to clk.
- SDI  in  1  master-to-slave data.
- SDO  out  1  slave-to-master data; idles 1.
- sdo_oe  out  1  high while a read data byte is being driven.
- sample_valid  in  1  one-clk strobe; a new sample is present.
- sample_data  in  96  sample; byte k = sample_data[8k+7:8k] maps to address OUT_BASE+k.
- ctrl1  out  8  current value of register 0x10.
- ctrl2  out  8  current value of register 0x11.
- busy  out  1  synchronized CS is low.

Behaviour:
- Reset values: SDO=1, sdo_oe=0, busy=0, ctrl1=ctrl2=0, all registers 0, shadow 0, state IDLE.
- CS, SPC and SDI each pass through SYNC_STAGES flops. Edge detects act on the synchronized copies. rise = SPC 0→1, fall = SPC 1→0.
- Frame: byte 0 is the command: bit7 = RW (1 = read), bits6:0 = address, MSB first. Data bytes follow. The address auto-increments after each data byte and wraps 0x7F→0x00.
- SDI is sampled on rise. SDO changes on fall.
- State machine:
  - IDLE: on CS fall, go to CMD; bitcnt=0.
  - CMD: shift SDI on each rise. On the 8th rise, latch rw and addr and go to DATA. If rw=1, load the read byte from addr into the shift register at that same clk.
  - DATA, read: each fall drives the next bit MSB-first on SDO with sdo_oe=1. After the 8th rise of a byte: addr+1, then load the next byte.
  - DATA, write: shift SDI on each rise. On the 8th rise, commit the byte to addr if that address is writable, then addr+1.
  - Any state: CS high (synchronized) goes to IDLE within the same clk. A partial byte is discarded (no commit, no increment); SDO=1, sdo_oe=0.
- Read map:
  - 0x0F → WHO_AM_I_VAL.
  - 0x10–0x1D → stored control bytes.
  - OUT_BASE..+11 → output registers.
  - All other addresses → 0x00.
- Writes take effect only at 0x10–0x1D. Writes to any other address are silently dropped; the address still increments.
- Sample coherency:
  - sample_valid always captures sample_data into a 96-bit shadow and sets a pending flag. When several strobes arrive, the last one wins.
  - Shadow is copied to the output registers at the first clk where synchronized CS is high and pending=1; pending then clears.
  - Output registers never change during a frame.
  - If CS is already idle, the copy happens on the clk after the strobe.
- sample_valid coinciding with reset: reset wins.
- Reset mid-frame: returns to IDLE and clears registers. The next CS fall starts a fresh frame.

Optional Feature:
- Macro: STATUS_REG_EN.
- Defined:
  - Address 0x1E is a read-only STATUS register: bit0 = XLDA, bit1 = GDA.
  - Both bits set when the shadow→output copy occurs.
  - XLDA clears when a read frame transfers any accel byte (OUT_BASE+6..+11) completely.
  - GDA clears when a read frame transfers any gyro byte (OUT_BASE+0..+5) completely.
  - If a copy and a clear fall on the same clk, set wins.
  - Writes to 0x1E are ignored.
- Undefined: 0x1E reads 0x00 and is not writable.

Test Plan:
- Read WHO_AM_I: CS low, command 0x8F, 8 more SPC clocks → SDO bits 0110_1001 (0x69), sdo_oe=1 only during the data byte; SDO=1 after CS high.
- Burst write then read: write 0x10 with data 0xA5,0x3C → ctrl1=0xA5, ctrl2=0x3C. Read 0x90 burst of 2 → 0xA5,0x3C.
- Sample burst: sample_valid with sample_data=96'h0C0B0A09_08070605_04030201 while idle, then read 0xA2 for 12 bytes → 0x01..0x0C in order.
- Coherency: start a 12-byte read, strobe a new sample after byte 3 → all 12 bytes come from the old sample; the next frame returns the new sample.
- Abort and wrap: write 0x1D, raise CS after 5 data bits → 0x1D unchanged. Read 0xFF for 2 bytes → 0x00 (addr 0x7F), 0x00 (addr 0x00, wrapped).
- STATUS_REG_EN: after a sample, read 0x9E → 0x03. Read 0xA8 for 1 byte (accel, OUT_BASE+6), then 0x9E → 0x02.

Source files
------------

// File: rtl/spi_imu_responder.sv
// SPI mode-3 responder emulating an accel/gyro IMU: 128-byte register map with WHO_AM_I,
// control bytes and a coherent 96-bit sample. Define STATUS_REG_EN to add the 0x1E STATUS register.
module spi_imu_responder #(
    parameter logic [7:0]  WHO_AM_I_VAL = 8'h69,
    parameter logic [6:0]  OUT_BASE     = 7'h22,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        CS,
    input  logic        SPC,
    input  logic        SDI,
    output logic        SDO,
    output logic        sdo_oe,
    input  logic        sample_valid,
    input  logic [95:0] sample_data,
    output logic [7:0]  ctrl1,
    output logic [7:0]  ctrl2,
    output logic        busy
);
    localparam int unsigned NUM_CTRL  = 14;
    localparam int unsigned OUT_BYTES = 12;
    localparam logic [6:0]  WHO_ADDR  = 7'h0F;
    localparam logic [6:0]  CTRL_BASE = 7'h10;
    localparam logic [6:0]  CTRL_LAST = 7'h1D;
`ifdef STATUS_REG_EN
    localparam logic [6:0]  STATUS_ADDR = 7'h1E;
`endif

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] cs_sync, spc_sync, sdi_sync;
    logic                   cs_prev, spc_prev;
    logic [2:0]             bitcnt, bitcnt_n;
    logic [7:0]             shreg, shreg_n;
    logic                   rw, rw_n;
    logic [6:0]             addr, addr_n;
    logic                   sdo_n, sdo_oe_n;
    logic [7:0]             ctrl_regs [NUM_CTRL];
    logic [95:0]            out_regs, shadow;
    logic                   pending;
    logic                   wr_en_c;
    logic [6:0]             rd_addr_c, out_off_c;
    logic [7:0]             rd_data_c, shift_in_c;
    logic                   cs_s, spc_s, sdi_s, rise_c, fall_c, cs_fall_c, copy_c;
`ifdef STATUS_REG_EN
    logic [1:0]             status;
    logic                   clr_xl_c, clr_g_c;
    logic [6:0]             cur_off_c;
`endif

    assign cs_s       = cs_sync[SYNC_STAGES-1];
    assign spc_s      = spc_sync[SYNC_STAGES-1];
    assign sdi_s      = sdi_sync[SYNC_STAGES-1];
    assign rise_c     = spc_s & ~spc_prev;
    assign fall_c     = ~spc_s & spc_prev;
    assign cs_fall_c  = cs_prev & ~cs_s;
    assign copy_c     = cs_s & pending;
    assign shift_in_c = {shreg[6:0], sdi_s};
    assign ctrl1      = ctrl_regs[0];
    assign ctrl2      = ctrl_regs[1];

    // Byte to preload: the command's target address, or the next address in a burst
    assign rd_addr_c = (state == CMD) ? shift_in_c[6:0] : 7'(addr + 7'd1);
    assign out_off_c = 7'(rd_addr_c - OUT_BASE);

    always_comb begin
        rd_data_c = '0;
        if (rd_addr_c == WHO_ADDR)
            rd_data_c = WHO_AM_I_VAL;
        else if (rd_addr_c >= CTRL_BASE && rd_addr_c <= CTRL_LAST)
            rd_data_c = ctrl_regs[4'(rd_addr_c - CTRL_BASE)];
        else if (out_off_c < 7'(OUT_BYTES))
            rd_data_c = out_regs[{out_off_c[3:0], 3'b000} +: 8];
`ifdef STATUS_REG_EN
        else if (rd_addr_c == STATUS_ADDR)
            rd_data_c = {6'b0, status};
`endif
    end

`ifdef STATUS_REG_EN
    assign cur_off_c = 7'(addr - OUT_BASE);
`endif

    // Next-state and output logic
    always_comb begin
        state_n  = state;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        rw_n     = rw;
        addr_n   = addr;
        sdo_n    = SDO;
        sdo_oe_n = sdo_oe;
        wr_en_c  = 1'b0;
`ifdef STATUS_REG_EN
        clr_xl_c = 1'b0;
        clr_g_c  = 1'b0;
`endif
        if (cs_s) begin
            state_n  = IDLE;
            bitcnt_n = '0;
            sdo_n    = 1'b1;
            sdo_oe_n = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cs_fall_c) begin
                        state_n  = CMD;
                        bitcnt_n = '0;
                    end
                end
                CMD: begin
                    if (rise_c) begin
                        shreg_n  = shift_in_c;
                        bitcnt_n = 3'(bitcnt + 3'd1);
                        if (bitcnt == 3'd7) begin
                            rw_n    = shift_in_c[7];
                            addr_n  = shift_in_c[6:0];
                            state_n = DATA;
                            if (shift_in_c[7])
                                shreg_n = rd_data_c;
                        end
                    end
                end
                DATA: begin
                    if (rw) begin
                        if (fall_c) begin
                            sdo_n    = shreg[7];
                            sdo_oe_n = 1'b1;
                            shreg_n  = {shreg[6:0], 1'b0};
                        end else if (rise_c) begin
                            bitcnt_n = 3'(bitcnt + 3'd1);
                            if (bitcnt == 3'd7) begin
                                addr_n  = 7'(addr + 7'd1);
                                shreg_n = rd_data_c;
`ifdef STATUS_REG_EN
                                clr_g_c  = cur_off_c < 7'd6;
                                clr_xl_c = cur_off_c >= 7'd6 && cur_off_c < 7'(OUT_BYTES);
`endif
                            end
                        end
                    end else if (rise_c) begin
                        shreg_n  = shift_in_c;
                        bitcnt_n = 3'(bitcnt + 3'd1);
                        if (bitcnt == 3'd7) begin
                            wr_en_c = addr >= CTRL_BASE && addr <= CTRL_LAST;
                            addr_n  = 7'(addr + 7'd1);
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cs_sync  <= '1;
            spc_sync <= '1;
            sdi_sync <= '0;
            cs_prev  <= 1'b1;
            spc_prev <= 1'b1;
            bitcnt   <= '0;
            shreg    <= '0;
            rw       <= 1'b0;
            addr     <= '0;
            SDO      <= 1'b1;
            sdo_oe   <= 1'b0;
            busy     <= 1'b0;
            out_regs <= '0;
            shadow   <= '0;
            pending  <= 1'b0;
            for (int i = 0; i < int'(NUM_CTRL); i++) ctrl_regs[i] <= '0;
`ifdef STATUS_REG_EN
            status   <= '0;
`endif
        end else begin
            state    <= state_n;
            cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS};
            spc_sync <= {spc_sync[SYNC_STAGES-2:0], SPC};
            sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], SDI};
            cs_prev  <= cs_s;
            spc_prev <= spc_s;
            bitcnt   <= bitcnt_n;
            shreg    <= shreg_n;
            rw       <= rw_n;
            addr     <= addr_n;
            SDO      <= sdo_n;
            sdo_oe   <= sdo_oe_n;
            busy     <= ~cs_sync[SYNC_STAGES-2];
            if (wr_en_c) ctrl_regs[4'(addr - CTRL_BASE)] <= shift_in_c;
            // Output registers only refresh between frames so a burst read stays coherent
            if (sample_valid) shadow <= sample_data;
            if (copy_c) out_regs <= shadow;
            pending <= sample_valid | (pending & ~copy_c);
`ifdef STATUS_REG_EN
            if (copy_c) status <= 2'b11;
            else        status <= status & ~{clr_g_c, clr_xl_c};
`endif
        end
    end
endmodule
